// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder controller: one full adder plus a carry flop, LSB first, N+2 cycles per operation.
// Optional SERIAL_SUB_EN adds a sub input (a-b via ~b and carry-in 1) and a signed-overflow output ovf.
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   sum_sh_q, sum_sh_d;
  logic [N-1:0]   sum_q, sum_d;
  logic [CW-1:0]  count_q, count_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           s_bit, carry_nx;

  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_nx = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    count_d  = count_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
`ifdef SERIAL_SUB_EN
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
`else
          b_sh_d  = b;
          carry_d = 1'b0;
`endif
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Shift-and-or form keeps N=1 legal (no [N-1:1] slice).
        sum_sh_d = (sum_sh_q >> 1) | (N'(s_bit) << (N - 1));
        carry_d  = carry_nx;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          state_d = DONE;
          sum_d   = sum_sh_d;
          cout_d  = carry_nx;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ carry_nx;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_SUB_EN
  assign ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: N=8 vector table, back-to-back, mid-RUN reset, and an N=1 instance.
// Sub-mode vectors are exercised when SERIAL_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int NW = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [NW-1:0] a_i = '0, b_i = '0;
  logic busy, done, cout;
  logic [NW-1:0] sum;
  logic start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic busy1, done1, cout1;
`ifdef SERIAL_SUB_EN
  logic sub_i = 1'b0;
  logic ovf, ovf1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [NW-1:0] prev_sum = '0;

  always #5 clock = ~clock;

  serial_add_ctrl #(.N(NW)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a_i), .b(b_i),
`ifdef SERIAL_SUB_EN
    .sub(sub_i), .ovf(ovf),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.N(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_SUB_EN
    .sub(1'b0), .ovf(ovf1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Start pulse before edge 0; busy expected cycles 1..N, done in cycle N+1, idle in N+2.
  task automatic run_op(input vec_t v);
    @(negedge clock);
    a_i = v.a; b_i = v.b; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub_i = v.sub;
`endif
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= NW; c++) begin
      check($sformatf("busy c%0d", c), busy, 1);
      check($sformatf("done low c%0d", c), done, 0);
      if (c == 1 || c == NW) check($sformatf("sum stable c%0d", c), sum, prev_sum);
      if (c == 3) begin
        a_i = ~v.a; b_i = v.a;
`ifdef SERIAL_SUB_EN
        sub_i = ~v.sub;
`endif
      end
      @(negedge clock);
    end
    check($sformatf("done %h+%h", v.a, v.b), done, 1);
    check("busy low in done", busy, 0);
    check($sformatf("sum %h,%h", v.a, v.b), sum, v.sum);
    check($sformatf("cout %h,%h", v.a, v.b), cout, v.cout);
`ifdef SERIAL_SUB_EN
    check($sformatf("ovf %h,%h,%b", v.a, v.b, v.sub), ovf, v.ovf);
`endif
    prev_sum = v.sum;
    @(negedge clock);
    check("done one cycle", done, 0);
    check("idle after done", busy, 0);
  endtask

  task automatic run_n1(input logic av, input logic bv, input logic es, input logic ec);
    @(negedge clock);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    check("n1 busy c1", busy1, 1);
    check("n1 done low c1", done1, 0);
    @(negedge clock);
    check("n1 done c2", done1, 1);
    check("n1 busy low c2", busy1, 0);
    check("n1 sum", sum1, es);
    check("n1 cout", cout1, ec);
    @(negedge clock);
    check("n1 done one cycle", done1, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int   d_cnt;
    int   d_cyc[2];
    logic [7:0] d_sum[2];
    logic d_cout[2];
    logic saw_done;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset n1 sum", sum1, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Start held high: second op captured at its IDLE edge, operands changed mid-RUN.
    d_cnt = 0;
    d_cyc = '{0, 0};
    d_sum = '{8'h00, 8'h00};
    d_cout = '{1'b1, 1'b1};
    @(negedge clock);
    a_i = 8'h10; b_i = 8'h20; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub_i = 1'b0;
`endif
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clock);
      if (cyc == 3) begin a_i = 8'h0F; b_i = 8'h0F; end
      if (cyc == 12) begin a_i = 8'hFF; b_i = 8'hFF; start = 1'b0; end
      if (done) begin
        if (d_cnt < 2) begin
          d_cyc[d_cnt] = cyc; d_sum[d_cnt] = sum; d_cout[d_cnt] = cout;
        end
        d_cnt++;
      end
    end
    check("b2b done count", d_cnt, 2);
    check("b2b done1 cycle", d_cyc[0], 9);
    check("b2b done2 cycle", d_cyc[1], 19);
    check("b2b sum1", d_sum[0], 8'h30);
    check("b2b cout1", d_cout[0], 0);
    check("b2b sum2", d_sum[1], 8'h1E);
    check("b2b cout2", d_cout[1], 0);
    prev_sum = 8'h1E;

    // Reset in RUN cycle 4 aborts with no done pulse.
    @(negedge clock);
    a_i = 8'hFF; b_i = 8'hFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("pre-reset busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    check("no done after abort", saw_done, 0);
    prev_sum = '0;
    run_op('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});

`ifdef SERIAL_SUB_EN
    run_op('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0});
    run_op('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
    run_op('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0});
`endif

    run_n1(1'b1, 1'b1, 1'b0, 1'b1);
    run_n1(1'b1, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
